// File: rtl/cpu_cycle_timer.sv
// CPU clock-enable generator: stretches each bus cycle to 6/8/12 master clocks
// by address and inserts the once-per-scanline DRAM refresh stall.
module cpu_cycle_timer #(
  parameter int FAST_CLKS    = 6,
  parameter int MID_CLKS     = 8,
  parameter int SLOW_CLKS    = 12,
  parameter int REFRESH_CLKS = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] next_addr,
  input  logic        next_access,
  input  logic        memsel,
  input  logic        dma_active,
  input  logic        refresh_req,
  output logic        cpu_en,
  output logic [3:0]  cur_len,
  output logic        refresh_active
);

  typedef enum logic {RUN = 1'b0, REFRESH = 1'b1} state_t;

  localparam logic [3:0] FAST_LEN     = 4'(FAST_CLKS);
  localparam logic [3:0] MID_LEN      = 4'(MID_CLKS);
  localparam logic [3:0] SLOW_LEN     = 4'(SLOW_CLKS);
  localparam logic [5:0] REFRESH_LAST = 6'(REFRESH_CLKS - 1);

  state_t      state;
  logic [5:0]  ctr;
  logic        refresh_pend;
  logic [3:0]  next_len;
  logic        last_clk;
  logic [7:0]  bank;
  logic [15:0] offset;

  assign bank   = next_addr[23:16];
  assign offset = next_addr[15:0];

  // Address-to-length decode; earlier branches take priority.
  always_comb begin
    next_len = MID_LEN;
    if (dma_active) begin
      next_len = MID_LEN;
    end else if (!next_access) begin
      next_len = FAST_LEN;
    end else if (bank >= 8'h40 && bank <= 8'h7F) begin
      next_len = MID_LEN;
    end else if (bank >= 8'hC0) begin
      next_len = memsel ? FAST_LEN : MID_LEN;
    end else if (offset >= 16'h8000) begin
      next_len = (bank[7] && memsel) ? FAST_LEN : MID_LEN;
    end else if (offset >= 16'h6000) begin
      next_len = MID_LEN;
    end else if (offset >= 16'h4200) begin
      next_len = FAST_LEN;
    end else if (offset >= 16'h4000) begin
      next_len = SLOW_LEN;
    end else if (offset >= 16'h2000) begin
      next_len = FAST_LEN;
    end else begin
      next_len = MID_LEN;
    end
  end

  assign last_clk       = (ctr == ({2'b00, cur_len} - 6'd1));
  assign cpu_en         = (state == RUN) && last_clk;
  assign refresh_active = (state == REFRESH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      ctr          <= 6'd0;
      cur_len      <= MID_LEN;
      refresh_pend <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (last_clk) begin
            ctr     <= 6'd0;
            cur_len <= next_len;
            // A request on the strobe edge itself is honoured right away.
            if (refresh_pend || refresh_req) begin
              state        <= REFRESH;
              refresh_pend <= 1'b0;
            end
          end else begin
            ctr <= ctr + 6'd1;
            if (refresh_req) refresh_pend <= 1'b1;
          end
        end
        REFRESH: begin
          if (ctr == REFRESH_LAST) begin
            state <= RUN;
            ctr   <= 6'd0;
          end else begin
            ctr <= ctr + 6'd1;
          end
        end
        default: begin
          state <= RUN;
          ctr   <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_cycle_timer.sv
// Directed bench for cpu_cycle_timer: per-address cycle lengths from a vector
// table, plus hand-written refresh and reset sequences.
module tb_cpu_cycle_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] next_addr = 24'h7E0000;
  logic        next_access = 1'b1;
  logic        memsel = 1'b0;
  logic        dma_active = 1'b0;
  logic        refresh_req = 1'b0;
  logic        cpu_en;
  logic [3:0]  cur_len;
  logic        refresh_active;

  int tests = 0;
  int failed = 0;

  cpu_cycle_timer dut (
    .clk(clk), .reset_n(reset_n), .next_addr(next_addr), .next_access(next_access),
    .memsel(memsel), .dma_active(dma_active), .refresh_req(refresh_req),
    .cpu_en(cpu_en), .cur_len(cur_len), .refresh_active(refresh_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic        access;
    logic        ms;
    logic        dma;
    int          len;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  // Counts falling edges until cpu_en is seen high; bounded.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_en && n < 200);
    if (!cpu_en) check("strobe_timeout", 0, 1);
  endtask

  task automatic set_inputs(input logic [23:0] a, input logic acc, input logic ms, input logic d);
    next_addr   = a;
    next_access = acc;
    memsel      = ms;
    dma_active  = d;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_en"}, int'(cpu_en), 0);
    check({tag, "_refresh_active"}, int'(refresh_active), 0);
    check({tag, "_cur_len"}, int'(cur_len), 8);
  endtask

  // Releases reset on a falling edge; the release period is clock 1.
  task automatic release_and_check(input string tag);
    int n;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_strobe(n);
    check({tag, "_first_en_clock"}, n + 1, 8);
  endtask

  initial begin
    int n;
    int act;

    vecs[0]  = '{24'h7E0000, 1'b1, 1'b0, 1'b0, 8};
    vecs[1]  = '{24'h004016, 1'b1, 1'b0, 1'b0, 12};
    vecs[2]  = '{24'h002100, 1'b1, 1'b0, 1'b0, 6};
    vecs[3]  = '{24'h808000, 1'b1, 1'b1, 1'b0, 6};
    vecs[4]  = '{24'h808000, 1'b1, 1'b0, 1'b0, 8};
    vecs[5]  = '{24'h004016, 1'b0, 1'b0, 1'b0, 6};
    vecs[6]  = '{24'h002100, 1'b1, 1'b0, 1'b1, 8};
    vecs[7]  = '{24'hC00000, 1'b1, 1'b1, 1'b0, 6};
    vecs[8]  = '{24'hC00000, 1'b1, 1'b0, 1'b0, 8};
    vecs[9]  = '{24'h400000, 1'b1, 1'b1, 1'b0, 8};
    vecs[10] = '{24'h001FFF, 1'b1, 1'b0, 1'b0, 8};
    vecs[11] = '{24'h004200, 1'b1, 1'b0, 1'b0, 6};
    vecs[12] = '{24'h0041FF, 1'b1, 1'b0, 1'b0, 12};
    vecs[13] = '{24'h006000, 1'b1, 1'b0, 1'b0, 8};
    vecs[14] = '{24'h008000, 1'b1, 1'b1, 1'b0, 8};
    vecs[15] = '{24'h7FFFFF, 1'b1, 1'b1, 1'b0, 8};
    vecs[16] = '{24'h005FFF, 1'b1, 1'b0, 1'b0, 6};
    vecs[17] = '{24'h004016, 1'b0, 1'b1, 1'b1, 8};

    // Reset state and first cycle (reset-vector fetch, 8 clocks).
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    release_and_check("reset");
    wait_strobe(n);
    check("idle_interval", n, 8);
    check("idle_cur_len", int'(cur_len), 8);

    // Table: inputs set at a strobe set the length of the following cycle.
    for (int i = 0; i < 18; i++) begin
      set_inputs(vecs[i].addr, vecs[i].access, vecs[i].ms, vecs[i].dma);
      wait_strobe(n);
      check($sformatf("vec%0d_interval", i), n, vecs[i].len);
      check($sformatf("vec%0d_cur_len", i), int'(cur_len), vecs[i].len);
    end

    // DMA cycle: changing inputs mid-cycle must not alter the running length.
    set_inputs(24'h002100, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    set_inputs(24'h004016, 1'b1, 1'b0, 1'b0);
    n = 3;
    do begin @(negedge clk); n++; end while (!cpu_en && n < 200);
    check("dma_midchange_interval", n, 8);
    wait_strobe(n);
    check("after_midchange_interval", n, 12);

    // Refresh request mid 6-clock cycle; a second request during the stall is dropped.
    set_inputs(24'h002100, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    n = 3;
    do begin @(negedge clk); n++; end while (!cpu_en && n < 200);
    check("refresh_pre_interval", n, 6);
    n = 0;
    act = 0;
    do begin
      @(negedge clk);
      n++;
      if (refresh_active) act++;
      if (cpu_en && refresh_active) check("en_during_refresh", 1, 0);
      refresh_req = (n == 10);
    end while (!cpu_en && n < 200);
    check("refresh_active_clocks", act, 40);
    check("refresh_gap", n, 46);
    wait_strobe(n);
    check("no_second_stall_interval", n, 6);

    // Request on the strobe clock itself: stall begins on the very next clock.
    refresh_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        refresh_req = 1'b0;
        check("sameclk_refresh_start", int'(refresh_active), 1);
      end
    end while (!cpu_en && n < 200);
    check("sameclk_refresh_gap", n, 46);

    // Reset at ctr=5 of a 12-clock cycle.
    set_inputs(24'h004016, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("slow_cur_len_before_reset", int'(cur_len), 12);
    reset_n = 1'b0;
    #1;
    check_reset_values("midcycle_reset");
    release_and_check("midcycle_reset");

    // Reset inside a refresh stall.
    set_inputs(24'h002100, 1'b1, 1'b0, 1'b0);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    repeat (9) @(negedge clk);
    check("inside_refresh_active", int'(refresh_active), 1);
    reset_n = 1'b0;
    #1;
    check_reset_values("refresh_reset");
    release_and_check("refresh_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
